// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register: drives the instruction-memory address,
// latches the returned word for decode, and stops fetching on a halt encoding.
module if_id_stage #(
   parameter logic [31:0] RESET_PC     = 32'h00000000,
   parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        Stall_In,
   input  logic        Redirect_In,
   input  logic [31:0] RedirectPC_In,
   input  logic [31:0] InstrMem_Data_In,
   output logic [31:0] PC_Out,
   output logic [31:0] Instr_Out,
   output logic [31:0] PCPlus4_Out,
   output logic        Valid_Out,
   output logic        Done_Out,
   output logic [1:0]  Dbg_State_Out
);

   // Valid_Out qualifies Instr_Out/PCPlus4_Out each cycle; there is no ready.
   // Stall_In is the only backpressure: while it is high every register holds.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
   localparam logic [3:0]  DRAIN_LOAD       = 4'(DRAIN_CYCLES - 1);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_plus4;
   logic        r_valid;
   logic        r_done;
   logic [3:0]  r_drain_cnt;

   logic [31:0] w_pc_next;
   logic [31:0] w_redirect_pc;
   logic        w_is_halt;

   assign w_pc_next     = r_pc + 32'd4;
   assign w_redirect_pc = RedirectPC_In & 32'hFFFF_FFFC;
   assign w_is_halt     = (InstrMem_Data_In == HALT_WORD);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC_ALIGNED;
         r_instr     <= 32'h0;
         r_pc_plus4  <= 32'h0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_drain_cnt <= 4'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (Redirect_In) begin
                  r_pc        <= w_redirect_pc;
                  r_instr     <= 32'h0;
                  r_pc_plus4  <= 32'h0;
                  r_valid     <= 1'b0;
                  r_drain_cnt <= 4'd0;
               end else if (Stall_In) begin
                  r_state <= S_FETCH;
               end else if (w_is_halt) begin
                  // PC parks on the halt address; the halt word never reaches decode.
                  r_instr     <= 32'h0;
                  r_valid     <= 1'b0;
                  r_drain_cnt <= DRAIN_LOAD;
                  r_state     <= S_DRAIN;
               end else begin
                  r_pc       <= w_pc_next;
                  r_instr    <= InstrMem_Data_In;
                  r_pc_plus4 <= w_pc_next;
                  r_valid    <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (Redirect_In) begin
                  // Halt was on the wrong path: resume fetching, done never raised.
                  r_pc        <= w_redirect_pc;
                  r_instr     <= 32'h0;
                  r_pc_plus4  <= 32'h0;
                  r_valid     <= 1'b0;
                  r_drain_cnt <= 4'd0;
                  r_state     <= S_FETCH;
               end else if (Stall_In) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_instr <= 32'h0;
                  r_valid <= 1'b0;
                  if (r_drain_cnt == 4'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_drain_cnt <= r_drain_cnt - 4'd1;
                  end
               end
            end
            S_DONE: begin
               r_instr <= 32'h0;
               r_valid <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign PC_Out        = r_pc;
   assign Instr_Out     = r_instr;
   assign PCPlus4_Out   = r_pc_plus4;
   assign Valid_Out     = r_valid;
   assign Done_Out      = r_done;
   assign Dbg_State_Out = r_state;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, hand-written halt/drain sequences,
// and a randomized run against a behavioural fetch model.
module tb_if_id_stage;

   localparam logic [31:0] HALT  = 32'hFFFFFFFF;
   localparam int          DRAIN = 4;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        Stall_In = 1'b0;
   logic        Redirect_In = 1'b0;
   logic [31:0] RedirectPC_In = 32'h0;
   logic [31:0] InstrMem_Data_In;
   logic [31:0] PC_Out, Instr_Out, PCPlus4_Out;
   logic        Valid_Out, Done_Out;
   logic [1:0]  Dbg_State_Out;

   logic [31:0] mem [0:63];

   int n_vec = 0;
   int n_bad = 0;

   // behavioural model
   logic [31:0] m_pc, m_instr, m_pc4;
   bit          m_valid, m_done, m_halted;
   int          m_drain_left;

   always #5 clk = ~clk;

   assign InstrMem_Data_In = mem[PC_Out[7:2]];

   if_id_stage #(.RESET_PC(32'h0), .HALT_WORD(HALT), .DRAIN_CYCLES(DRAIN)) dut (
      .CLOCK(clk), .RESET(RESET), .Stall_In(Stall_In), .Redirect_In(Redirect_In),
      .RedirectPC_In(RedirectPC_In), .InstrMem_Data_In(InstrMem_Data_In),
      .PC_Out(PC_Out), .Instr_Out(Instr_Out), .PCPlus4_Out(PCPlus4_Out),
      .Valid_Out(Valid_Out), .Done_Out(Done_Out), .Dbg_State_Out(Dbg_State_Out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_update(input bit rst, input bit stall, input bit redir,
                               input logic [31:0] rpc, input logic [31:0] word);
      if (rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
         m_valid = 0; m_done = 0; m_halted = 0; m_drain_left = 0;
      end else if (m_done) begin
         m_valid = 0;
      end else if (redir) begin
         m_pc = {rpc[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0;
         m_valid = 0; m_halted = 0; m_drain_left = 0;
      end else if (stall) begin
         m_valid = m_valid;
      end else if (m_halted) begin
         m_instr = 32'h0; m_valid = 0;
         m_drain_left--;
         if (m_drain_left == 0) begin
            m_done = 1; m_halted = 0;
         end
      end else if (word == HALT) begin
         m_halted = 1; m_drain_left = DRAIN; m_instr = 32'h0; m_valid = 0;
      end else begin
         m_instr = word; m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1;
      end
   endtask

   // Drive inputs, take one rising edge, then settle on the falling edge.
   task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] rpc);
      logic [31:0] word;
      RESET = rst; Stall_In = stall; Redirect_In = redir; RedirectPC_In = rpc;
      word = mem[m_pc[7:2]];
      @(posedge clk);
      model_update(rst, stall, redir, rpc, word);
      @(negedge clk);
   endtask

   task automatic chk_model();
      logic [31:0] exp_state;
      exp_state = m_done ? 32'd2 : (m_halted ? 32'd1 : 32'd0);
      chk("pc", PC_Out, m_pc);
      chk("instr", Instr_Out, m_instr);
      chk("valid", {31'b0, Valid_Out}, {31'b0, m_valid});
      chk("done", {31'b0, Done_Out}, {31'b0, m_done});
      chk("state", {30'b0, Dbg_State_Out}, exp_state);
      if (!(m_halted || m_done)) chk("pc_plus4", PCPlus4_Out, m_pc4);
   endtask

   task automatic chk_outs(input string name, input logic [31:0] pc, input logic [31:0] instr,
                           input bit valid, input bit done);
      chk({name, ".pc"}, PC_Out, pc);
      chk({name, ".instr"}, Instr_Out, instr);
      chk({name, ".valid"}, {31'b0, Valid_Out}, {31'b0, valid});
      chk({name, ".done"}, {31'b0, Done_Out}, {31'b0, done});
   endtask

   typedef struct {
      bit          rst, stall, redir;
      logic [31:0] rpc;
      logic [31:0] exp_pc, exp_instr, exp_pc4;
      bit          exp_valid, exp_done;
   } vec_t;

   vec_t tbl [10];

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h00000013 + 32'(i << 8);
      mem[0]  = 32'h20010005;
      mem[1]  = 32'h11111111;
      mem[2]  = 32'h22222222;
      mem[3]  = HALT;
      mem[63] = 32'hABCD0123;

      tbl[0] = '{1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,  0, 0};
      tbl[1] = '{0, 0, 0, 32'h0,        32'h4,        32'h20010005, 32'h4,  1, 0};
      tbl[2] = '{0, 0, 0, 32'h0,        32'h8,        32'h11111111, 32'h8,  1, 0};
      tbl[3] = '{0, 1, 0, 32'h0,        32'h8,        32'h11111111, 32'h8,  1, 0};
      tbl[4] = '{0, 1, 0, 32'h0,        32'h8,        32'h11111111, 32'h8,  1, 0};
      tbl[5] = '{0, 1, 0, 32'h0,        32'h8,        32'h11111111, 32'h8,  1, 0};
      tbl[6] = '{0, 0, 0, 32'h0,        32'hC,        32'h22222222, 32'hC,  1, 0};
      tbl[7] = '{0, 1, 1, 32'h43,       32'h40,       32'h0,        32'h0,  0, 0};
      tbl[8] = '{0, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0,        32'h0,  0, 0};
      tbl[9] = '{0, 0, 0, 32'h0,        32'h0,        32'hABCD0123, 32'h0,  1, 0};

      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_done = 0; m_halted = 0; m_drain_left = 0;
      @(negedge clk);

      // directed vector table
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
         chk_outs($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_instr,
                  tbl[i].exp_valid, tbl[i].exp_done);
         chk($sformatf("vec%0d.pc_plus4", i), PCPlus4_Out, tbl[i].exp_pc4);
      end

      // halt at PC 12 drains for DRAIN edges, then DONE ignores inputs, then reset
      step(1, 0, 0, 0);
      step(0, 0, 1, 32'hC);
      step(0, 0, 0, 0);
      chk_outs("halt_edge", 32'hC, 32'h0, 0, 0);
      for (int i = 1; i < DRAIN; i++) begin
         step(0, 0, 0, 0);
         chk_outs($sformatf("drain%0d", i), 32'hC, 32'h0, 0, 0);
      end
      step(0, 0, 0, 0);
      chk_outs("done_rise", 32'hC, 32'h0, 0, 1);
      step(0, 1, 1, 32'h200);
      chk_outs("done_ignores", 32'hC, 32'h0, 0, 1);
      step(1, 0, 0, 0);
      chk_outs("reset_in_done", 32'h0, 32'h0, 0, 0);
      chk("reset_in_done.pc_plus4", PCPlus4_Out, 32'h0);

      // wrong-path halt: redirect on the second drain cycle
      step(0, 0, 1, 32'hC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'h100);
      chk_outs("drain_redirect", 32'h100, 32'h0, 0, 0);
      chk("drain_redirect.state", {30'b0, Dbg_State_Out}, 32'd0);
      step(0, 0, 0, 0);
      chk_outs("after_redirect", 32'h104, 32'h20010005, 1, 0);

      // mid-drain reset
      step(0, 0, 1, 32'hC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      chk_outs("reset_mid_drain", 32'h0, 32'h0, 0, 0);

      // randomized run against the model
      for (int i = 0; i < 64; i++)
         mem[i] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
      step(1, 0, 0, 0);
      chk_model();
      for (int i = 0; i < 3000; i++) begin
         bit rst, stall, redir;
         logic [31:0] rpc;
         rst   = m_done ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 150) == 0);
         stall = ($urandom_range(0, 4) == 0);
         redir = ($urandom_range(0, 14) == 0);
         rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
         step(rst, stall, redir, rpc);
         chk_model();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: the byte address fetched after reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF: the instruction encoding that stops fetch.
REQ-003 Parameter DRAIN_CYCLES, default 4: cycles, from 1 to 15, that are counted after a halt before Done_Out rises.
REQ-004 CLOCK  in  1: the single clock; all state SHALL update on the rising edge.
REQ-005 RESET  in  1: synchronous, active-high reset, sampled on the rising edge of CLOCK.
REQ-006 Stall_In  in  1: hazard stall from the decode stage; the PC and IF/ID register hold.
REQ-007 Redirect_In  in  1: taken-branch redirect from a later stage.
REQ-008 RedirectPC_In  in  32: the redirect target byte address.
REQ-009 InstrMem_Data_In  in  32: combinational instruction-memory read data for the address on PC_Out, valid in the same cycle.
REQ-010 PC_Out  out  32: the current fetch byte address, driving the instruction-memory address.
REQ-011 Instr_Out  out  32: the registered instruction presented to the decode stage.
REQ-012 PCPlus4_Out  out  32: the registered PC+4 of Instr_Out, consumed by decode and the branch adder.
REQ-013 Valid_Out  out  1: Instr_Out holds a real instruction; when 0, Instr_Out SHALL be 32'h0 (NOP).
REQ-014 Done_Out  out  1: the halt has been fetched and the pipeline has drained; it is sticky until RESET.

Function
REQ-015 The block SHALL implement a three-state FSM with the states FETCH, DRAIN and DONE.
REQ-016 In FETCH, the per-cycle priority SHALL be Redirect_In > Stall_In > halt detect > normal fetch.
REQ-017 Redirect in any state except DONE: PC <= {RedirectPC_In[31:2],2'b00}; Instr_Out <= 0; Valid_Out <= 0; PCPlus4_Out <= 0; state <= FETCH.
REQ-018 Redirect SHALL override Stall_In in the same cycle.
REQ-019 Stall (no redirect): PC, Instr_Out, PCPlus4_Out, Valid_Out and the drain counter SHALL all hold.
REQ-020 Normal fetch: PC <= PC+4; Instr_Out <= InstrMem_Data_In; PCPlus4_Out <= PC+4; Valid_Out <= 1.
REQ-021 Halt detect, i.e. FETCH with InstrMem_Data_In == HALT_WORD, no stall and no redirect: PC holds; Instr_Out <= 0; Valid_Out <= 0; counter <= DRAIN_CYCLES-1; state <= DRAIN.
REQ-022 The halt word itself SHALL never appear on Instr_Out.
REQ-023 In DRAIN without stall or redirect, the block SHALL output a NOP with Valid_Out=0 and hold the PC.
REQ-024 In DRAIN, when the counter is non-zero it SHALL decrement; when the counter is 0, state <= DONE and Done_Out <= 1 on the same edge.
REQ-025 A redirect in DRAIN means the halt was wrong-path: the block SHALL return to FETCH, clear the counter, and leave Done_Out at 0.
REQ-026 In DONE, the block SHALL ignore Stall_In, Redirect_In and InstrMem_Data_In, hold the PC, and hold Valid_Out=0 and Done_Out=1.
REQ-027 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, with no error flagged.
REQ-028 PC[1:0] SHALL always be 2'b00.
REQ-029 The latency from the instruction-memory read to Instr_Out SHALL be exactly 1 cycle; PC_Out SHALL be a registered output.

Reset
REQ-030 RESET=1 at an edge SHALL set: PC=RESET_PC, Instr_Out=0, PCPlus4_Out=0, Valid_Out=0, Done_Out=0, counter=0, state=FETCH.
REQ-031 RESET SHALL take priority over every other input, in every state, including mid-DRAIN and in DONE.
REQ-032 In the first cycle after RESET deasserts, PC_Out SHALL equal RESET_PC and a normal fetch SHALL occur at the next edge.

Verification
REQ-033 Reset, then memory returns 32'h20010005 at PC 0 -> after 1 edge: Instr_Out=32'h20010005, PCPlus4_Out=4, Valid_Out=1, PC_Out=4.
REQ-034 Stall_In=1 for 3 cycles at PC=8 -> PC_Out stays 8 and Instr_Out/Valid_Out are unchanged; the fetch resumes at 8 on the first unstalled edge.
REQ-035 Redirect_In=1 with Stall_In=1 and RedirectPC_In=32'h00000043 -> next cycle: PC_Out=32'h40, Valid_Out=0, Instr_Out=0.
REQ-036 Halt word fetched at PC=12 with DRAIN_CYCLES=4 and no stalls -> Done_Out=1 exactly 4 edges after the halt edge; PC_Out stays 12 throughout.
REQ-037 Halt fetched, then a redirect to 32'h100 on the 2nd DRAIN cycle -> state FETCH, Done_Out stays 0, PC_Out=32'h100; also RESET asserted in DONE -> all outputs return to their REQ-030 values.
REQ-038 PC forced to 32'hFFFFFFFC via redirect, then one normal fetch -> PC_Out=0 and PCPlus4_Out=0.
